// File: rtl/sample_frame_scheduler_if.sv
// rtl/sample_frame_scheduler_if.sv - stage-sequencer bus between the sample timing domain and the effect stages
`timescale 1ns/1ps
interface sample_frame_scheduler_if #(
  parameter int CLK_FREQ    = 10_000_000,
  parameter int TARGET_FREQ = 48_000,
  parameter int N_STAGES    = 4
);
  localparam int AW  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int FCW = $clog2(CLK_FREQ / TARGET_FREQ) + 1;

  logic                enable;
  logic                sample_valid;
  logic [N_STAGES-1:0] stage_start;
  logic [N_STAGES-1:0] stage_done;
  logic [AW-1:0]       active_stage;
  logic                busy;
  logic                frame_done;
  logic                overrun;
  logic                timeout;
  logic [15:0]         overrun_count;
  logic [FCW-1:0]      frame_cycles;

  modport master (
    output enable, sample_valid, stage_done,
    input  stage_start, active_stage, busy, frame_done, overrun, timeout, overrun_count, frame_cycles
  );

  modport slave (
    input  enable, sample_valid, stage_done,
    output stage_start, active_stage, busy, frame_done, overrun, timeout, overrun_count, frame_cycles
  );
endinterface

// File: rtl/sample_frame_scheduler.sv
// rtl/sample_frame_scheduler.sv - per-sample frame sequencer: starts stages 0..N-1 in order, flags overrun/timeout
`timescale 1ns/1ps
module sample_frame_scheduler #(
  parameter int CLK_FREQ      = 10_000_000,
  parameter int TARGET_FREQ   = 48_000,
  parameter int N_STAGES      = 4,
  parameter int STAGE_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  sample_frame_scheduler_if.slave  bus
);
  localparam int BUDGET = CLK_FREQ / TARGET_FREQ;
  localparam int AW     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int FCW    = $clog2(BUDGET) + 1;
  localparam int WW     = $clog2(STAGE_TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       active_stage_q, active_stage_d;
  logic [N_STAGES-1:0] stage_start_q, stage_start_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         overrun_count_q, overrun_count_d;
  logic [FCW-1:0]      frame_cycles_q, frame_cycles_d;
  logic [FCW-1:0]      cyc_q, cyc_d;
  logic [WW-1:0]       wait_q, wait_d;

  logic [AW-1:0]       next_stage;
  logic                done_seen;
  logic                last_stage;
  logic [FCW-1:0]      cyc_inc;

  assign next_stage = active_stage_q + AW'(1);
  assign done_seen  = bus.stage_done[active_stage_q];
  assign last_stage = (active_stage_q == AW'(N_STAGES - 1));
  assign cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + FCW'(1);

  always_comb begin
    state_d         = state_q;
    active_stage_d  = active_stage_q;
    stage_start_d   = '0;
    busy_d          = busy_q;
    frame_done_d    = 1'b0;
    overrun_d       = 1'b0;
    timeout_d       = 1'b0;
    overrun_count_d = overrun_count_q;
    frame_cycles_d  = frame_cycles_q;
    cyc_d           = cyc_q;
    wait_d          = wait_q;

    // Any strobe outside IDLE is dropped, including the cycle the frame ends.
    if (bus.sample_valid && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
      if (overrun_count_q != 16'hFFFF) overrun_count_d = overrun_count_q + 16'd1;
    end

    if (state_q != S_IDLE) cyc_d = cyc_inc;

    case (state_q)
      S_IDLE: begin
        if (bus.sample_valid && bus.enable) begin
          state_d        = S_START;
          active_stage_d = '0;
          busy_d         = 1'b1;
          stage_start_d  = N_STAGES'(1);
          cyc_d          = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        // A done seen on the final wait cycle still advances the frame.
        if (done_seen) begin
          if (last_stage) begin
            state_d        = S_IDLE;
            busy_d         = 1'b0;
            frame_done_d   = 1'b1;
            frame_cycles_d = cyc_inc;
          end else begin
            state_d        = S_START;
            active_stage_d = next_stage;
            stage_start_d  = N_STAGES'(1) << next_stage;
          end
        end else if (wait_q == WW'(STAGE_TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      active_stage_q  <= '0;
      stage_start_q   <= '0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
      timeout_q       <= 1'b0;
      overrun_count_q <= '0;
      frame_cycles_q  <= '0;
      cyc_q           <= '0;
      wait_q          <= '0;
    end else begin
      state_q         <= state_d;
      active_stage_q  <= active_stage_d;
      stage_start_q   <= stage_start_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      overrun_q       <= overrun_d;
      timeout_q       <= timeout_d;
      overrun_count_q <= overrun_count_d;
      frame_cycles_q  <= frame_cycles_d;
      cyc_q           <= cyc_d;
      wait_q          <= wait_d;
    end
  end

  assign bus.stage_start   = stage_start_q;
  assign bus.active_stage  = active_stage_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.overrun       = overrun_q;
  assign bus.timeout       = timeout_q;
  assign bus.overrun_count = overrun_count_q;
  assign bus.frame_cycles  = frame_cycles_q;
endmodule
